operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 39 +++
 rtl/operand_fwd_mux.sv | 37 +++
 rtl/operand_fetch.sv | 115 +++++++++++
 tb/tb_operand_fetch.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared CPU header for the operand-fetch stage: bus widths, instruction field
// positions, enable/reset polarity constants and the ID-stage register layout.
package operand_fetch_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

  localparam int RA_MSB = 25;
  localparam int RA_LSB = 21;
  localparam int RB_MSB = 20;
  localparam int RB_LSB = 16;

  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;
  localparam logic ENABLE_      = 1'b0;
  localparam logic RESET_ENABLE = 1'b1;

  typedef struct packed {
    logic       en;
    word_addr_t pc;
    word_data_t insn;
    word_data_t ra_data;
    word_data_t rb_data;
  } id_stage_t;

  function automatic reg_addr_t ra_field(input word_data_t insn);
    return insn[RA_MSB:RA_LSB];
  endfunction

  function automatic reg_addr_t rb_field(input word_data_t insn);
    return insn[RB_MSB:RB_LSB];
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Bypass selection for one source operand: the youngest matching writer
// (EX, then MEM) supplies the value, otherwise the register file does.
module operand_fwd_mux
  import operand_fetch_pkg::*;
(
  input  reg_addr_t  i_field,
  input  word_data_t i_gpr_data,
  input  logic       i_ex_en,
  input  logic       i_ex_gpr_we_,
  input  reg_addr_t  i_ex_dst_addr,
  input  word_data_t i_ex_fwd_data,
  input  logic       i_mem_en,
  input  logic       i_mem_gpr_we_,
  input  reg_addr_t  i_mem_dst_addr,
  input  word_data_t i_mem_fwd_data,
  output word_data_t o_data
);

  logic w_ex_hit;
  logic w_mem_hit;

  // Register 0 is an ordinary register here, so address 0 forwards too.
  assign w_ex_hit  = (i_ex_en == ENABLE) && (i_ex_gpr_we_ == ENABLE_) &&
                     (i_ex_dst_addr == i_field);
  assign w_mem_hit = (i_mem_en == ENABLE) && (i_mem_gpr_we_ == ENABLE_) &&
                     (i_mem_dst_addr == i_field);

  always_comb begin
    o_data = i_gpr_data;
    if (w_ex_hit) begin
      o_data = i_ex_fwd_data;
    end else if (w_mem_hit) begin
      o_data = i_mem_fwd_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: register-file addressing, EX/MEM forwarding,
// load-use bubble insertion and the ID output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int HAZ_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_en,
  input  word_addr_t           if_pc,
  input  word_data_t           if_insn,
  output reg_addr_t            gpr_rd_addr_0,
  output reg_addr_t            gpr_rd_addr_1,
  input  word_data_t           gpr_rd_data_0,
  input  word_data_t           gpr_rd_data_1,
  input  logic                 ex_en,
  input  logic                 ex_gpr_we_,
  input  reg_addr_t            ex_dst_addr,
  input  word_data_t           ex_fwd_data,
  input  logic                 ex_is_load,
  input  logic                 mem_en,
  input  logic                 mem_gpr_we_,
  input  reg_addr_t            mem_dst_addr,
  input  word_data_t           mem_fwd_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ld_hazard,
  output logic                 id_en,
  output word_addr_t           id_pc,
  output word_data_t           id_insn,
  output word_data_t           id_ra_data,
  output word_data_t           id_rb_data,
  output logic [HAZ_CNT_W-1:0] haz_cnt
);

  localparam id_stage_t ID_BUBBLE = '{en: DISABLE, default: '0};

  reg_addr_t            w_ra;
  reg_addr_t            w_rb;
  word_data_t           w_ra_data;
  word_data_t           w_rb_data;
  logic                 w_ld_hazard;
  id_stage_t            w_id_next;
  id_stage_t            r_id;
  logic [HAZ_CNT_W-1:0] r_haz_cnt;

  assign w_ra          = ra_field(if_insn);
  assign w_rb          = rb_field(if_insn);
  assign gpr_rd_addr_0 = w_ra;
  assign gpr_rd_addr_1 = w_rb;

  operand_fwd_mux u_fwd_ra (
    .i_field        (w_ra),
    .i_gpr_data     (gpr_rd_data_0),
    .i_ex_en        (ex_en),
    .i_ex_gpr_we_   (ex_gpr_we_),
    .i_ex_dst_addr  (ex_dst_addr),
    .i_ex_fwd_data  (ex_fwd_data),
    .i_mem_en       (mem_en),
    .i_mem_gpr_we_  (mem_gpr_we_),
    .i_mem_dst_addr (mem_dst_addr),
    .i_mem_fwd_data (mem_fwd_data),
    .o_data         (w_ra_data)
  );

  operand_fwd_mux u_fwd_rb (
    .i_field        (w_rb),
    .i_gpr_data     (gpr_rd_data_1),
    .i_ex_en        (ex_en),
    .i_ex_gpr_we_   (ex_gpr_we_),
    .i_ex_dst_addr  (ex_dst_addr),
    .i_ex_fwd_data  (ex_fwd_data),
    .i_mem_en       (mem_en),
    .i_mem_gpr_we_  (mem_gpr_we_),
    .i_mem_dst_addr (mem_dst_addr),
    .i_mem_fwd_data (mem_fwd_data),
    .o_data         (w_rb_data)
  );

  // Both fields are checked whatever the opcode; a spurious bubble is cheaper than decode.
  assign w_ld_hazard = (if_en == ENABLE) && (ex_en == ENABLE) && (ex_is_load == ENABLE) &&
                       (ex_gpr_we_ == ENABLE_) &&
                       ((ex_dst_addr == w_ra) || (ex_dst_addr == w_rb));
  assign ld_hazard   = w_ld_hazard;

  assign w_id_next = '{en: if_en, pc: if_pc, insn: if_insn,
                       ra_data: w_ra_data, rb_data: w_rb_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_id      <= ID_BUBBLE;
      r_haz_cnt <= '0;
    end else if (flush) begin
      r_id <= ID_BUBBLE;
    end else if (!stall) begin
      if (w_ld_hazard) begin
        r_id <= ID_BUBBLE;
        if (r_haz_cnt != '1) begin
          r_haz_cnt <= r_haz_cnt + HAZ_CNT_W'(1);
        end
      end else begin
        r_id <= w_id_next;
      end
    end
  end

  assign id_en      = r_id.en;
  assign id_pc      = r_id.pc;
  assign id_insn    = r_id.insn;
  assign id_ra_data = r_id.ra_data;
  assign id_rb_data = r_id.rb_data;
  assign haz_cnt    = r_haz_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomised and directed checks of operand_fetch against a cycle-level
// behavioural model of the decode slot, forwarding and bubble rules.
module tb_operand_fetch;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_en;
  logic [29:0]   if_pc;
  logic [31:0]   if_insn;
  logic [4:0]    gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0]   gpr_rd_data_0, gpr_rd_data_1;
  logic          ex_en, ex_gpr_we_, ex_is_load;
  logic [4:0]    ex_dst_addr;
  logic [31:0]   ex_fwd_data;
  logic          mem_en, mem_gpr_we_;
  logic [4:0]    mem_dst_addr;
  logic [31:0]   mem_fwd_data;
  logic          stall, flush;
  logic          ld_hazard;
  logic          id_en;
  logic [29:0]   id_pc;
  logic [31:0]   id_insn, id_ra_data, id_rb_data;
  logic [CW-1:0] haz_cnt;

  logic [31:0] rf [32];
  assign gpr_rd_data_0 = rf[gpr_rd_addr_0];
  assign gpr_rd_data_1 = rf[gpr_rd_addr_1];

  // Reference state of the ID register and bubble counter
  logic          m_en;
  logic [29:0]   m_pc;
  logic [31:0]   m_insn, m_ra, m_rb;
  logic [CW-1:0] m_cnt;

  logic [130:0] out_vec, exp_vec;
  assign out_vec = {id_en, id_pc, id_insn, id_ra_data, id_rb_data, haz_cnt};
  assign exp_vec = {m_en, m_pc, m_insn, m_ra, m_rb, m_cnt};

  int checks = 0;
  int errors = 0;

  operand_fetch #(.HAZ_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en(ex_en), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
    .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
    .mem_en(mem_en), .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr),
    .mem_fwd_data(mem_fwd_data),
    .stall(stall), .flush(flush), .ld_hazard(ld_hazard),
    .id_en(id_en), .id_pc(id_pc), .id_insn(id_insn),
    .id_ra_data(id_ra_data), .id_rb_data(id_rb_data), .haz_cnt(haz_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] f_ra(input logic [31:0] insn);
    logic [4:0] r;
    r = insn[25:21];
    return r;
  endfunction

  function automatic logic [4:0] f_rb(input logic [31:0] insn);
    logic [4:0] r;
    r = insn[20:16];
    return r;
  endfunction

  // Youngest writer of a register wins; otherwise the register file value.
  function automatic logic [31:0] ref_operand(input logic [4:0] a);
    if (ex_en && !ex_gpr_we_ && ex_dst_addr == a) return ex_fwd_data;
    if (mem_en && !mem_gpr_we_ && mem_dst_addr == a) return mem_fwd_data;
    return rf[a];
  endfunction

  function automatic logic ref_hazard();
    logic reads_load_dst;
    reads_load_dst = (ex_dst_addr == f_ra(if_insn)) || (ex_dst_addr == f_rb(if_insn));
    return if_en && ex_en && ex_is_load && !ex_gpr_we_ && reads_load_dst;
  endfunction

  task automatic idle();
    if_en = 0; if_pc = '0; if_insn = '0;
    ex_en = 0; ex_gpr_we_ = 1; ex_dst_addr = '0; ex_fwd_data = '0; ex_is_load = 0;
    mem_en = 0; mem_gpr_we_ = 1; mem_dst_addr = '0; mem_fwd_data = '0;
    stall = 0; flush = 0;
  endtask

  // Advance one clock, updating the model from the inputs as seen before the edge.
  task automatic tick();
    logic          n_en;
    logic [29:0]   n_pc;
    logic [31:0]   n_insn, n_ra, n_rb;
    logic [CW-1:0] n_cnt;
    {n_en, n_pc, n_insn, n_ra, n_rb, n_cnt} = exp_vec;
    if (reset) begin
      {n_en, n_pc, n_insn, n_ra, n_rb, n_cnt} = '0;
    end else if (flush) begin
      {n_en, n_pc, n_insn, n_ra, n_rb} = '0;
    end else if (stall) begin
      // everything holds
    end else if (ref_hazard()) begin
      {n_en, n_pc, n_insn, n_ra, n_rb} = '0;
      if (n_cnt != {CW{1'b1}}) n_cnt = n_cnt + 1;
    end else begin
      n_en = if_en; n_pc = if_pc; n_insn = if_insn;
      n_ra = ref_operand(f_ra(if_insn));
      n_rb = ref_operand(f_rb(if_insn));
    end
    @(posedge clk);
    {m_en, m_pc, m_insn, m_ra, m_rb, m_cnt} = {n_en, n_pc, n_insn, n_ra, n_rb, n_cnt};
    #1;
  endtask

  task automatic test_reset();
    idle();
    {m_en, m_pc, m_insn, m_ra, m_rb, m_cnt} = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    if_insn = 32'h0128_0000;  // ra=9, rb=8
    #1;
    checks++;
    if (out_vec !== 131'b0) begin
      errors++; $display("FAIL reset_regs act=%h exp=0", out_vec);
    end
    checks++;
    if ({gpr_rd_addr_0, gpr_rd_addr_1} !== {5'd9, 5'd8}) begin
      errors++; $display("FAIL reset_addr act=%0d/%0d exp=9/8", gpr_rd_addr_0, gpr_rd_addr_1);
    end
    @(posedge clk); #1;
    reset = 0;
    idle();
  endtask

  task automatic test_basic_read();
    idle();
    rf[3] = 32'h11; rf[4] = 32'h22;
    if_en = 1; if_pc = 30'h123; if_insn = {6'h0, 5'd3, 5'd4, 16'hBEEF};
    tick();
    checks++;
    if ({id_en, id_ra_data, id_rb_data} !== {1'b1, 32'h11, 32'h22}) begin
      errors++; $display("FAIL basic_read act=%0d %h %h exp=1 11 22", id_en, id_ra_data, id_rb_data);
    end
    checks++;
    if (out_vec !== exp_vec) begin
      errors++; $display("FAIL basic_model act=%h exp=%h", out_vec, exp_vec);
    end
  endtask

  task automatic test_forward_priority();
    idle();
    if_en = 1; if_insn = {6'h0, 5'd5, 5'd6, 16'h0};
    ex_en = 1; ex_gpr_we_ = 0; ex_dst_addr = 5; ex_fwd_data = 32'hAAAA;
    mem_en = 1; mem_gpr_we_ = 0; mem_dst_addr = 5; mem_fwd_data = 32'hBBBB;
    tick();
    checks++;
    if (id_ra_data !== 32'hAAAA) begin
      errors++; $display("FAIL fwd_ex_wins act=%h exp=aaaa", id_ra_data);
    end
    ex_gpr_we_ = 1;
    tick();
    checks++;
    if (id_ra_data !== 32'hBBBB) begin
      errors++; $display("FAIL fwd_mem act=%h exp=bbbb", id_ra_data);
    end
    if_insn = 32'h0; ex_gpr_we_ = 0; ex_dst_addr = 0; ex_fwd_data = 32'hC0C0;
    tick();
    checks++;
    if ({id_ra_data, id_rb_data} !== {32'hC0C0, 32'hC0C0}) begin
      errors++; $display("FAIL fwd_r0 act=%h %h exp=c0c0 c0c0", id_ra_data, id_rb_data);
    end
  endtask

  task automatic test_load_use();
    idle();
    if_en = 1; if_pc = 30'h40; if_insn = {6'h0, 5'd1, 5'd7, 16'h0};
    ex_en = 1; ex_gpr_we_ = 0; ex_is_load = 1; ex_dst_addr = 7; ex_fwd_data = 32'hDEAD;
    #1;
    checks++;
    if (ld_hazard !== 1'b1) begin
      errors++; $display("FAIL ld_hazard_comb act=%b exp=1", ld_hazard);
    end
    tick();
    checks++;
    if ({id_en, haz_cnt} !== {1'b0, CW'(1)}) begin
      errors++; $display("FAIL ld_bubble act=%b cnt=%0d exp=0 cnt=1", id_en, haz_cnt);
    end
    ex_en = 0; ex_is_load = 0;
    mem_en = 1; mem_gpr_we_ = 0; mem_dst_addr = 7; mem_fwd_data = 32'h5A5A_0007;
    #1;
    checks++;
    if (ld_hazard !== 1'b0) begin
      errors++; $display("FAIL ld_clear act=%b exp=0", ld_hazard);
    end
    tick();
    checks++;
    if ({id_en, id_rb_data, haz_cnt} !== {1'b1, 32'h5A5A_0007, CW'(1)}) begin
      errors++; $display("FAIL ld_mem_fwd act=%b %h cnt=%0d exp=1 5a5a0007 cnt=1", id_en, id_rb_data, haz_cnt);
    end
  endtask

  task automatic test_flush_stall();
    logic [130:0] held;
    idle();
    if_en = 1; if_pc = 30'h77; if_insn = $urandom;
    tick();
    flush = 1; stall = 1;
    ex_en = 1; ex_gpr_we_ = 0; ex_is_load = 1; ex_dst_addr = f_ra(if_insn);
    tick();
    checks++;
    if (out_vec[130:CW] !== '0 || out_vec !== exp_vec) begin
      errors++; $display("FAIL flush_stall act=%h exp=%h", out_vec, exp_vec);
    end
    flush = 0; stall = 0; ex_en = 0;
    if_pc = 30'h99; if_insn = $urandom;
    tick();
    held = exp_vec;
    stall = 1; if_pc = 30'h3; if_insn = $urandom;
    ex_en = 1; ex_dst_addr = f_rb(if_insn);
    repeat (2) tick();
    checks++;
    if (out_vec !== held) begin
      errors++; $display("FAIL stall_hold act=%h exp=%h", out_vec, held);
    end
    stall = 0;
  endtask

  task automatic test_saturation();
    idle();
    if_en = 1; if_insn = {6'h0, 5'd2, 5'd3, 16'h0};
    ex_en = 1; ex_gpr_we_ = 0; ex_is_load = 1; ex_dst_addr = 2;
    repeat (20) tick();
    checks++;
    if (haz_cnt !== {CW{1'b1}}) begin
      errors++; $display("FAIL sat_cnt act=%0d exp=%0d", haz_cnt, {CW{1'b1}});
    end
    checks++;
    if (out_vec !== exp_vec) begin
      errors++; $display("FAIL sat_model act=%h exp=%h", out_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if_en = $urandom_range(0, 3) != 0;
      if_pc = $urandom;
      if_insn = {$urandom} & 32'hFCE7_FFFF;  // ra/rb confined to 0..7
      ex_en = $urandom; ex_gpr_we_ = $urandom; ex_is_load = $urandom_range(0, 3) == 0;
      ex_dst_addr = $urandom_range(0, 7); ex_fwd_data = $urandom;
      mem_en = $urandom; mem_gpr_we_ = $urandom;
      mem_dst_addr = $urandom_range(0, 7); mem_fwd_data = $urandom;
      stall = $urandom_range(0, 7) == 0; flush = $urandom_range(0, 9) == 0;
      rf[$urandom_range(0, 7)] = $urandom;
      #1;
      checks++;
      if ({gpr_rd_addr_0, gpr_rd_addr_1, ld_hazard} !== {f_ra(if_insn), f_rb(if_insn), ref_hazard()}) begin
        errors++; $display("FAIL rand_comb n=%0d act=%0d/%0d/%b exp=%0d/%0d/%b", n,
          gpr_rd_addr_0, gpr_rd_addr_1, ld_hazard, f_ra(if_insn), f_rb(if_insn), ref_hazard());
      end
      tick();
      checks++;
      if (out_vec !== exp_vec) begin
        errors++; $display("FAIL rand_regs n=%0d act=%h exp=%h", n, out_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    if_en = 1; if_pc = 30'h55; if_insn = {6'h0, 5'd4, 5'd9, 16'h0};
    tick();
    ex_en = 1; ex_gpr_we_ = 0; ex_is_load = 1; ex_dst_addr = 9;
    #2 reset = 1;
    {m_en, m_pc, m_insn, m_ra, m_rb, m_cnt} = '0;
    #1;
    checks++;
    if (out_vec !== 131'b0) begin
      errors++; $display("FAIL async_reset act=%h exp=0", out_vec);
    end
    checks++;
    if ({ld_hazard, gpr_rd_addr_1} !== {1'b1, 5'd9}) begin
      errors++; $display("FAIL reset_comb act=%b/%0d exp=1/9", ld_hazard, gpr_rd_addr_1);
    end
    tick();
    reset = 0; ex_en = 0;
    tick();
    checks++;
    if (out_vec !== exp_vec || id_en !== 1'b1) begin
      errors++; $display("FAIL post_reset act=%h exp=%h", out_vec, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_forward_priority();
    test_load_use();
    test_flush_stall();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
